// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit that drives a req/ack data bus and stalls the pipeline front.
// Optional build macro MEM_ALIGN_CHECK_EN enables misaligned half/word detection (addr_err).
//
// state | meaning
// IDLE  | waiting for a load/store at the EX/MEM outputs
// REQ   | bus_req asserted, waiting for bus_ack or timeout
// DONE  | rdata/bus_err valid for one cycle; pipeline advances
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Down-counter preload: terminal count 0 is reached in REQ cycle TIMEOUT_CYCLES.
   localparam logic [7:0] TC_LOAD = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        bus_err_q, bus_err_d;
   logic [1:0]  ld_size_q, ld_size_d;
   logic        ld_sign_q, ld_sign_d;
   logic [1:0]  ld_lane_q, ld_lane_d;

   logic        misaligned;
   logic        req;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      misaligned = 1'b0;
      if (mem_size == 2'b01)
         misaligned = addr[0];
      else if (mem_size[1])
         misaligned = (addr[1:0] != 2'b00);
   end
`else
   assign misaligned = 1'b0;
`endif

   assign req      = (mem_rd | mem_wr) & ~misaligned;
   assign addr_err = (state_q == IDLE) & (mem_rd | mem_wr) & misaligned;
   assign stall    = ((state_q == IDLE) & req) | (state_q == REQ);

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = wdata;
      case (mem_size)
         2'b00: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = wdata;
         end
      endcase
   end

   always_comb begin
      ld_byte = bus_rdata[7:0];
      case (ld_lane_q)
         2'd0:    ld_byte = bus_rdata[7:0];
         2'd1:    ld_byte = bus_rdata[15:8];
         2'd2:    ld_byte = bus_rdata[23:16];
         default: ld_byte = bus_rdata[31:24];
      endcase
      ld_half = ld_lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (ld_size_q)
         2'b00:   ld_ext = {{24{ld_sign_q & ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = {{16{ld_sign_q & ld_half[15]}}, ld_half};
         default: ld_ext = bus_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      bus_err_d   = bus_err_q;
      ld_size_d   = ld_size_q;
      ld_sign_d   = ld_sign_q;
      ld_lane_d   = ld_lane_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d     = REQ;
               cnt_d       = TC_LOAD;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_wr;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_be_d    = be_calc;
               bus_wdata_d = wdata_calc;
               ld_size_d   = mem_size;
               ld_sign_d   = mem_sign;
               ld_lane_d   = addr[1:0];
            end
         end
         REQ: begin
            // An ack on the terminal-count cycle still completes normally.
            if (bus_ack) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               rdata_d   = bus_we_q ? 32'd0 : ld_ext;
            end else if (cnt_q == 8'd0) begin
               state_d   = DONE;
               bus_req_d = 1'b0;
               rdata_d   = 32'd0;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DONE: begin
            state_d   = IDLE;
            rdata_d   = 32'd0;
            bus_err_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         bus_err_q   <= 1'b0;
         ld_size_q   <= 2'd0;
         ld_sign_q   <= 1'b0;
         ld_lane_q   <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
         bus_err_q   <= bus_err_d;
         ld_size_q   <= ld_size_d;
         ld_sign_q   <= ld_sign_d;
         ld_lane_q   <= ld_lane_d;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;
   assign rdata     = rdata_q;
   assign bus_err   = bus_err_q;

endmodule
